core_seq: RTL and testbench
===========================

Name: core_seq

Overview:
- Parametrised instruction sequencer that drives the 50-bit core instruction word, replacing hand-written per-cycle testbench instruction streams.
- On one start pulse it runs a full weight-stationary convolution:
  - per kernel position (kij): weight fill, weight load, activation fill, execute, drain to pmem;
  - then a final accumulation pass that reads every kij partial sum back through the SFP with acc asserted.
- Sits beside corelet/xmem/pmem in the core top; its inst output feeds the core inst input directly.

Parameters:
- ROW, 8, PE array rows; weights per kij = ROW xmem words.
- COL, 8, PE array columns; also the pipeline flush depth.
- XADDR_W, 8, xmem address width.
- PADDR_W, 9, pmem address width.
- KIJ_W, 4, width of the kij count (maximum 15 positions).
- LEN_W, 6, width of the activation/output count per kij.
- INST_W, 50, instruction word width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- cfg_kij_num  in  KIJ_W  number of kernel positions K.
- cfg_act_len  in  LEN_W  activations (= outputs) per kij, N.
- cfg_w_base  in  XADDR_W  xmem base address of weights.
- cfg_a_base  in  XADDR_W  xmem base address of activations.
- l0_ready  in  1  L0 can accept a write.
- ofifo_valid  in  1  OFIFO holds a full output row.
- inst  out  INST_W  instruction word to the core.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at the end of the operation.
- out_valid  out  1  pulse: SFP output for out_idx is complete.
- out_idx  out  LEN_W  output index associated with out_valid.

Behaviour:
- Instruction field map (all bits registered):
  - bit 0 load, 1 execute, 2 mode (always 0), 3 l0_wr, 4 l0_rd, 5 ififo_rd, 6 ififo_wr, 7 ofifo_rd.
  - [15:8] A0_xmem, 16 WEN0, 17 CEN0, [25:18] A1_xmem, 26 CEN1.
  - [35:27] A_pmem, 36 WEN_pmem, 37 CEN_pmem, 38 acc, 39 psum_bypass (always 0).
  - [49:40] reserved, always 0.
  - CEN and WEN are active-low.
- Idle word: CEN0=CEN1=CEN_pmem=1, WEN0=WEN_pmem=1, every other bit 0.
- Reset values: inst = idle word; busy=0, done=0, out_valid=0, out_idx=0; FSM in IDLE; all counters 0.
- Reset mid-operation returns to IDLE in one cycle. No partial completion, no done pulse.
- SRAM read latency is 1 cycle. Any consumer of xmem/pmem read data (l0_wr, acc) is asserted exactly 1 cycle after the matching CEN-low read cycle.
- State machine (k = kij counter, i = item counter):
  - IDLE: on start, latch cfg; go to W_FILL with k=0. If K==0 or N==0, stay IDLE and pulse done the next cycle.
  - W_FILL: issue ROW reads at A0 = w_base + k*ROW + i, CEN0=0, WEN0=1.
    - A read is issued only in cycles where l0_ready=1; otherwise the counter holds and CEN0=1.
    - l0_wr follows each issued read by 1 cycle.
  - W_LOAD: l0_rd=1 and load=1 for ROW cycles, then idle word for COL cycles of flush.
  - A_FILL: as W_FILL, but N reads at A0 = a_base + k*N + i.
  - EXEC: l0_rd=1 and execute=1 for N cycles.
  - DRAIN: in each cycle with ofifo_valid=1, assert ofifo_rd=1 together with CEN_pmem=0, WEN_pmem=0, A_pmem = k*N + j.
    - After N writes: if k<K-1, increment k and go to W_FILL; otherwise go to ACC.
  - ACC: for o = 0..N-1 and, inner loop, kk = 0..K-1: read pmem at A_pmem = kk*N + o (CEN_pmem=0, WEN_pmem=1).
    - acc=1 one cycle after each read.
    - out_valid pulses, with out_idx=o, one cycle after the acc of kk=K-1.
  - FINISH: one cycle with done=1, busy=0; then IDLE.
- pmem address arithmetic wraps modulo 2^PADDR_W. xmem address arithmetic wraps modulo 2^XADDR_W. No error flag.
- A start pulse while busy is ignored. cfg changes while busy have no effect.
- DRAIN has no timeout; it waits indefinitely for ofifo_valid.

Decomposition:
- Package core_seq_pkg holds:
  - the state enum;
  - bit-position localparams for every instruction field;
  - the IDLE_INST constant.
- One sub-module, core_seq_addr_gen: registered base+offset counter with a step enable, a terminal-count flag and modulo wrap. It is instantiated for the xmem and pmem address streams.

Test Plan:
- Reset, then idle for 5 cycles -> inst = idle word (bits 16, 17, 26, 36, 37 set; all others 0); busy=0.
- K=1, N=4, w_base=0, a_base=8, l0_ready=1, ofifo_valid tied 1:
  - -> A0 sequence 0..7 then 8..11;
  - -> exactly 4 pmem writes at addresses 0..3;
  - -> 4 out_valid pulses with out_idx 0..3;
  - -> one done pulse.
- K=3, N=2:
  - -> weight reads at xmem 16..23 during kij 2;
  - -> ACC reads pmem in order 0,2,4,1,3,5;
  - -> out_valid exactly after the reads at addresses 4 and 5.
- l0_ready low for 3 cycles in the middle of W_FILL -> CEN0=1 during the stall; no skipped or duplicated addresses; l0_wr count = ROW.
- Reset asserted during EXEC, then start reissued -> clean rerun from W_FILL; no done pulse from the aborted run.
- K=0 start -> done one cycle later; no CEN ever driven low.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types and instruction-word field positions for the core instruction sequencer.
package core_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_FILL,
      S_W_LOAD,
      S_A_FILL,
      S_EXEC,
      S_DRAIN,
      S_ACC,
      S_ACC_TAIL,
      S_FINISH
   } state_t;

   localparam int INST_WORD_W  = 50;

   // Instruction word bit positions.
   localparam int B_LOAD       = 0;
   localparam int B_EXECUTE    = 1;
   localparam int B_MODE       = 2;
   localparam int B_L0_WR      = 3;
   localparam int B_L0_RD      = 4;
   localparam int B_IFIFO_RD   = 5;
   localparam int B_IFIFO_WR   = 6;
   localparam int B_OFIFO_RD   = 7;
   localparam int B_A0_LSB     = 8;
   localparam int B_WEN0       = 16;
   localparam int B_CEN0       = 17;
   localparam int B_A1_LSB     = 18;
   localparam int B_CEN1       = 26;
   localparam int B_APMEM_LSB  = 27;
   localparam int B_WEN_PMEM   = 36;
   localparam int B_CEN_PMEM   = 37;
   localparam int B_ACC        = 38;
   localparam int B_BYPASS     = 39;

   // Every SRAM deselected with write disabled; all control strobes low.
   localparam logic [INST_WORD_W-1:0] IDLE_INST =
      (INST_WORD_W'(1) << B_WEN0)     |
      (INST_WORD_W'(1) << B_CEN0)     |
      (INST_WORD_W'(1) << B_CEN1)     |
      (INST_WORD_W'(1) << B_WEN_PMEM) |
      (INST_WORD_W'(1) << B_CEN_PMEM);

endpackage

// File: rtl/core_seq_addr_gen.sv
// Registered address counter: loads a base, advances by a stride on each step,
// wraps modulo 2^AW, and flags the step that completes 'limit' addresses.
module core_seq_addr_gen
   import core_seq_pkg::*;
#(
   parameter int AW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] stride,
   input  logic [CW-1:0] limit,
   output logic [AW-1:0] addr,
   output logic          last
);

   logic [CW-1:0] cnt_q;

   // Address and count register; load takes priority over step.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values.
      if (reset) begin
         addr  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         addr  <= base;
         cnt_q <= '0;
      end else if (step) begin
         addr  <= addr + stride;
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign last = ((cnt_q + CW'(1)) == limit);

endmodule

// File: rtl/core_seq.sv
// Instruction sequencer: runs a weight-stationary convolution over K kernel
// positions and a final pmem accumulation pass, emitting one registered
// instruction word per cycle.
module core_seq
   import core_seq_pkg::*;
#(
   parameter int ROW     = 8,
   parameter int COL     = 8,
   parameter int XADDR_W = 8,
   parameter int PADDR_W = 9,
   parameter int KIJ_W   = 4,
   parameter int LEN_W   = 6,
   parameter int INST_W  = 50
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [KIJ_W-1:0]   cfg_kij_num,
   input  logic [LEN_W-1:0]   cfg_act_len,
   input  logic [XADDR_W-1:0] cfg_w_base,
   input  logic [XADDR_W-1:0] cfg_a_base,
   input  logic               l0_ready,
   input  logic               ofifo_valid,
   output logic [INST_W-1:0]  inst,
   output logic               busy,
   output logic               done,
   output logic               out_valid,
   output logic [LEN_W-1:0]   out_idx
);

   localparam int CNT_W = 16;

   state_t             state_q, state_d;
   logic [KIJ_W-1:0]   kn_q, k_q, k_d;
   logic [LEN_W-1:0]   n_q, o_q, o_d;
   logic [XADDR_W-1:0] wb_q, ab_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [INST_W-1:0]  inst_q, inst_d;
   logic               busy_q, busy_d, done_q, done_d, ov_q, ov_d;
   logic [LEN_W-1:0]   oidx_q, oidx_d;
   // Read-to-consumer pipeline: SRAM data arrives one cycle after the read.
   logic               xrd_q, xrd_d, accrd_q, accrd_d;
   logic               last1_q, last1_d, last2_q;
   logic [LEN_W-1:0]   idx1_q, idx1_d, idx2_q;

   logic               x_load, x_step, x_last, p_load, p_step, p_last;
   logic [XADDR_W-1:0] x_base, x_addr, w_next_base, a_base_k;
   logic [PADDR_W-1:0] p_base, p_addr, p_stride, p_base_k;
   logic [CNT_W-1:0]   x_limit, p_limit;

   assign w_next_base = wb_q + (XADDR_W'(k_q) + XADDR_W'(1)) * XADDR_W'(ROW);
   assign a_base_k    = ab_q + XADDR_W'(k_q) * XADDR_W'(n_q);
   assign p_base_k    = PADDR_W'(k_q) * PADDR_W'(n_q);
   assign x_limit     = (state_q == S_W_FILL) ? CNT_W'(ROW) : CNT_W'(n_q);
   assign p_limit     = (state_q == S_ACC) ? CNT_W'(kn_q) : CNT_W'(n_q);
   assign p_stride    = (state_q == S_ACC) ? PADDR_W'(n_q) : PADDR_W'(1);

   core_seq_addr_gen #(.AW(XADDR_W), .CW(CNT_W)) u_xgen (
      .clk(clk), .reset(reset), .load(x_load), .step(x_step), .base(x_base),
      .stride(XADDR_W'(1)), .limit(x_limit), .addr(x_addr), .last(x_last)
   );

   core_seq_addr_gen #(.AW(PADDR_W), .CW(CNT_W)) u_pgen (
      .clk(clk), .reset(reset), .load(p_load), .step(p_step), .base(p_base),
      .stride(p_stride), .limit(p_limit), .addr(p_addr), .last(p_last)
   );

   // Next-state, counter and next-instruction logic.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      state_d = state_q;
      k_d     = k_q;
      o_d     = o_q;
      cnt_d   = cnt_q;
      inst_d  = INST_W'(IDLE_INST);
      busy_d  = (state_q != S_IDLE) && (state_q != S_FINISH);
      done_d  = 1'b0;
      ov_d    = last2_q;
      oidx_d  = last2_q ? idx2_q : oidx_q;
      x_load  = 1'b0;
      x_step  = 1'b0;
      x_base  = '0;
      p_load  = 1'b0;
      p_step  = 1'b0;
      p_base  = '0;
      xrd_d   = 1'b0;
      accrd_d = 1'b0;
      last1_d = 1'b0;
      idx1_d  = '0;

      inst_d[B_L0_WR] = xrd_q;
      inst_d[B_ACC]   = accrd_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_kij_num == '0 || cfg_act_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_W_FILL;
                  k_d     = '0;
                  busy_d  = 1'b1;
                  x_load  = 1'b1;
                  x_base  = cfg_w_base;
               end
            end
         end
         S_W_FILL, S_A_FILL: begin
            if (l0_ready) begin
               inst_d[B_CEN0]                 = 1'b0;
               inst_d[B_A0_LSB +: XADDR_W]    = x_addr;
               x_step                         = 1'b1;
               xrd_d                          = 1'b1;
               if (x_last) begin
                  state_d = (state_q == S_W_FILL) ? S_W_LOAD : S_EXEC;
                  cnt_d   = '0;
               end
            end
         end
         S_W_LOAD: begin
            if (cnt_q < CNT_W'(ROW)) begin
               inst_d[B_L0_RD] = 1'b1;
               inst_d[B_LOAD]  = 1'b1;
            end
            if (cnt_q == CNT_W'(ROW + COL - 1)) begin
               state_d = S_A_FILL;
               cnt_d   = '0;
               x_load  = 1'b1;
               x_base  = a_base_k;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_EXEC: begin
            inst_d[B_L0_RD]   = 1'b1;
            inst_d[B_EXECUTE] = 1'b1;
            if (cnt_q == CNT_W'(n_q) - CNT_W'(1)) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
               p_load  = 1'b1;
               p_base  = p_base_k;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if (ofifo_valid) begin
               inst_d[B_OFIFO_RD]             = 1'b1;
               inst_d[B_CEN_PMEM]             = 1'b0;
               inst_d[B_WEN_PMEM]             = 1'b0;
               inst_d[B_APMEM_LSB +: PADDR_W] = p_addr;
               p_step                         = 1'b1;
               if (p_last) begin
                  if (k_q == kn_q - KIJ_W'(1)) begin
                     state_d = S_ACC;
                     o_d     = '0;
                     p_load  = 1'b1;
                     p_base  = '0;
                  end else begin
                     state_d = S_W_FILL;
                     k_d     = k_q + KIJ_W'(1);
                     x_load  = 1'b1;
                     x_base  = w_next_base;
                  end
               end
            end
         end
         S_ACC: begin
            inst_d[B_CEN_PMEM]             = 1'b0;
            inst_d[B_APMEM_LSB +: PADDR_W] = p_addr;
            p_step                         = 1'b1;
            accrd_d                        = 1'b1;
            last1_d                        = p_last;
            idx1_d                         = o_q;
            if (p_last) begin
               if (o_q == n_q - LEN_W'(1)) begin
                  state_d = S_ACC_TAIL;
                  cnt_d   = '0;
               end else begin
                  o_d    = o_q + LEN_W'(1);
                  p_load = 1'b1;
                  p_base = PADDR_W'(o_q) + PADDR_W'(1);
               end
            end
         end
         S_ACC_TAIL: begin
            // Let the last acc and out_valid leave the pipeline before done.
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FINISH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, configuration, pipeline and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         kn_q    <= '0;
         k_q     <= '0;
         n_q     <= '0;
         o_q     <= '0;
         wb_q    <= '0;
         ab_q    <= '0;
         cnt_q   <= '0;
         inst_q  <= INST_W'(IDLE_INST);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ov_q    <= 1'b0;
         oidx_q  <= '0;
         xrd_q   <= 1'b0;
         accrd_q <= 1'b0;
         last1_q <= 1'b0;
         last2_q <= 1'b0;
         idx1_q  <= '0;
         idx2_q  <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            kn_q <= cfg_kij_num;
            n_q  <= cfg_act_len;
            wb_q <= cfg_w_base;
            ab_q <= cfg_a_base;
         end
         state_q <= state_d;
         k_q     <= k_d;
         o_q     <= o_d;
         cnt_q   <= cnt_d;
         inst_q  <= inst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ov_q    <= ov_d;
         oidx_q  <= oidx_d;
         xrd_q   <= xrd_d;
         accrd_q <= accrd_d;
         last1_q <= last1_d;
         last2_q <= last1_q;
         idx1_q  <= idx1_d;
         idx2_q  <= idx1_q;
      end
   end

   assign inst      = inst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = ov_q;
   assign out_idx   = oidx_q;

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: stimulus pushes expected SRAM accesses,
// out_valid indices and done pulses; a negedge monitor pops and compares.
module tb_core_seq;

   localparam logic [49:0] IDLE_WORD = 50'h30_0403_0000;

   typedef struct {
      logic [8:0] addr;
      bit         last;
      logic [5:0] idx;
   } prd_t;

   logic        clk, reset, start, l0_ready, ofifo_valid;
   logic [3:0]  cfg_kij_num;
   logic [5:0]  cfg_act_len;
   logic [7:0]  cfg_w_base, cfg_a_base;
   logic [49:0] inst;
   logic        busy, done, out_valid;
   logic [5:0]  out_idx;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cycle = -1;
   int exp_done = 0;
   int xrd_cnt, l0wr_cnt, ov_cnt, pw_cnt, load_cnt, exec_cnt, stall_cnt;

   logic [7:0] exp_x[$];
   logic [8:0] exp_pw[$];
   prd_t       exp_pr[$];
   logic [8:0] pr_log[$];

   core_seq dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_kij_num(cfg_kij_num), .cfg_act_len(cfg_act_len),
      .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base),
      .l0_ready(l0_ready), .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done),
      .out_valid(out_valid), .out_idx(out_idx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Monitor: compares every SRAM access and strobe against the scoreboard.
   initial begin
      bit cen0_low, pwr, prd, cur_last, cen0_prev, prd_prev;
      bit last_d1, last_d2, rst_prev, rdy_prev, ofv_prev;
      logic [5:0] cur_idx, idx_d1, idx_d2;
      prd_t e;
      cen0_prev = 0; prd_prev = 0; last_d1 = 0; last_d2 = 0;
      idx_d1 = 0; idx_d2 = 0; rst_prev = 1; rdy_prev = 1; ofv_prev = 1;
      forever begin
         @(negedge clk);
         if (reset) begin
            cen0_prev = 0; prd_prev = 0; last_d1 = 0; last_d2 = 0; rst_prev = 1;
         end else begin
            cen0_low = !inst[17];
            pwr      = !inst[37] && !inst[36];
            prd      = !inst[37] && inst[36];
            cur_last = 0;
            cur_idx  = 0;
            if (inst[49:39] != 0 || inst[2] || !inst[26]) fail("fixed_fields");
            if (!rdy_prev) stall_cnt++;
            if (cen0_low) begin
               xrd_cnt++;
               if (!rdy_prev) fail("xrd_while_l0_not_ready");
               if (!inst[16]) fail("xmem_write");
               if (exp_x.size() == 0) fail("xrd_unexpected");
               else check("xrd_addr", inst[15:8], exp_x.pop_front());
            end
            if (inst[3]) l0wr_cnt++;
            if (inst[0]) load_cnt++;
            if (inst[1]) exec_cnt++;
            if (!rst_prev && (inst[3] || cen0_prev)) check("l0_wr_timing", inst[3], cen0_prev);
            if (!rst_prev && (inst[38] || prd_prev)) check("acc_timing", inst[38], prd_prev);
            if (pwr) begin
               pw_cnt++;
               if (!ofv_prev) fail("pmem_write_without_ofifo_valid");
               check("ofifo_rd_with_write", inst[7], 1);
               if (exp_pw.size() == 0) fail("pmem_write_unexpected");
               else check("pmem_write_addr", inst[35:27], exp_pw.pop_front());
            end else if (inst[7]) fail("ofifo_rd_without_write");
            if (prd) begin
               pr_log.push_back(inst[35:27]);
               if (exp_pr.size() == 0) fail("pmem_read_unexpected");
               else begin
                  e = exp_pr.pop_front();
                  check("pmem_read_addr", inst[35:27], e.addr);
                  cur_last = e.last;
                  cur_idx  = e.idx;
               end
            end
            if (!rst_prev && (out_valid || last_d2)) begin
               check("out_valid_timing", out_valid, last_d2);
               if (out_valid && last_d2) check("out_idx", out_idx, idx_d2);
            end
            if (out_valid) ov_cnt++;
            if (done) begin
               check("busy_low_at_done", busy, 0);
               if (exp_done > 0) begin
                  exp_done--;
                  done_cycle = cyc;
               end else fail("done_unexpected");
            end
            last_d2 = last_d1; idx_d2 = idx_d1;
            last_d1 = cur_last; idx_d1 = cur_idx;
            cen0_prev = cen0_low; prd_prev = prd; rst_prev = 0;
         end
         rdy_prev = l0_ready;
         ofv_prev = ofifo_valid;
      end
   end

   // Expected access streams for one operation, written straight from the address formulas.
   task automatic push_op(input int k_num, input int n, input int wb, input int ab);
      prd_t e;
      if (k_num == 0 || n == 0) return;
      for (int k = 0; k < k_num; k++) begin
         for (int i = 0; i < 8; i++) exp_x.push_back(8'(wb + k * 8 + i));
         for (int i = 0; i < n; i++) exp_x.push_back(8'(ab + k * n + i));
         for (int j = 0; j < n; j++) exp_pw.push_back(9'(k * n + j));
      end
      for (int o = 0; o < n; o++)
         for (int kk = 0; kk < k_num; kk++) begin
            e.addr = 9'(kk * n + o);
            e.last = (kk == k_num - 1);
            e.idx  = 6'(o);
            exp_pr.push_back(e);
         end
   endtask

   task automatic issue_start(input int k_num, input int n, input int wb, input int ab,
                              output int t0);
      @(posedge clk); #1;
      cfg_kij_num = 4'(k_num);
      cfg_act_len = 6'(n);
      cfg_w_base  = 8'(wb);
      cfg_a_base  = 8'(ab);
      start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_kij_num = 4'hF; cfg_act_len = 6'h3F; cfg_w_base = 8'hAA; cfg_a_base = 8'h55;
   endtask

   task automatic run_op(input int k_num, input int n, input int wb, input int ab);
      int t0, w;
      bit zero;
      zero = (k_num == 0 || n == 0);
      xrd_cnt = 0; l0wr_cnt = 0; ov_cnt = 0; pw_cnt = 0; load_cnt = 0; exec_cnt = 0;
      push_op(k_num, n, wb, ab);
      exp_done++;
      issue_start(k_num, n, wb, ab, t0);
      @(negedge clk);
      check("busy_after_start", busy, !zero);
      w = 0;
      while (exp_done != 0 && w < 4000) begin
         @(negedge clk);
         w++;
      end
      if (exp_done != 0) begin
         fail("done_timeout");
         exp_done = 0;
      end
      if (zero) check("zero_done_latency", done_cycle, t0 + 1);
      repeat (4) @(negedge clk);
      check("xrd_left", exp_x.size(), 0);
      check("pmem_write_left", exp_pw.size(), 0);
      check("pmem_read_left", exp_pr.size(), 0);
      check("xrd_count", xrd_cnt, zero ? 0 : k_num * (8 + n));
      check("l0_wr_count", l0wr_cnt, zero ? 0 : k_num * (8 + n));
      check("load_count", load_cnt, zero ? 0 : k_num * 8);
      check("exec_count", exec_cnt, zero ? 0 : k_num * n);
      check("pmem_write_count", pw_cnt, zero ? 0 : k_num * n);
      check("out_valid_count", ov_cnt, zero ? 0 : n);
      check("busy_idle_after", busy, 0);
      check("inst_idle_after", inst, IDLE_WORD);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_order[6];
      int t0, w;
      acc_order = '{0, 2, 4, 1, 3, 5};
      reset = 1'b1; start = 1'b0; l0_ready = 1'b1; ofifo_valid = 1'b1;
      cfg_kij_num = '0; cfg_act_len = '0; cfg_w_base = '0; cfg_a_base = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle after reset.
      repeat (5) begin
         @(negedge clk);
         check("reset_inst", inst, IDLE_WORD);
         check("reset_busy", busy, 0);
      end
      check("reset_done", done, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_idx", out_idx, 0);

      // Single kernel position, four outputs.
      run_op(1, 4, 0, 8);

      // Three kernel positions: ACC order is kij-inner.
      pr_log.delete();
      run_op(3, 2, 0, 40);
      check("acc_read_total", pr_log.size(), 6);
      for (int i = 0; i < 6 && i < pr_log.size(); i++)
         check($sformatf("acc_order_%0d", i), pr_log[i], acc_order[i]);

      // l0_ready stall in the middle of weight fill.
      stall_cnt = 0;
      fork
         run_op(1, 2, 0, 100);
         begin
            w = 0;
            @(negedge clk);
            while (xrd_cnt < 3 && w < 200) begin
               @(negedge clk);
               w++;
            end
            @(posedge clk); #1 l0_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 l0_ready = 1'b1;
         end
      join
      check("stall_cycles", stall_cnt, 3);

      // Reset during EXEC, then a clean rerun.
      xrd_cnt = 0;
      push_op(1, 4, 0, 8);
      issue_start(1, 4, 0, 8, t0);
      w = 0;
      while (xrd_cnt < 12 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (xrd_cnt < 12) fail("abort_fill_timeout");
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      exp_x.delete(); exp_pw.delete(); exp_pr.delete();
      @(negedge clk);
      check("abort_inst_idle", inst, IDLE_WORD);
      check("abort_busy", busy, 0);
      repeat (10) @(negedge clk);
      run_op(1, 4, 0, 8);

      // Zero-length configurations finish immediately without SRAM traffic.
      run_op(0, 4, 0, 8);
      run_op(2, 0, 0, 8);

      // xmem wrap-around and DRAIN waiting on a late ofifo_valid.
      ofifo_valid = 1'b0;
      fork
         run_op(1, 1, 250, 255);
         begin
            w = 0;
            @(negedge clk);
            while (xrd_cnt < 9 && w < 200) begin
               @(negedge clk);
               w++;
            end
            repeat (30) @(posedge clk);
            @(negedge clk);
            check("drain_waits_busy", busy, 1);
            check("drain_no_early_write", pw_cnt, 0);
            @(posedge clk); #1 ofifo_valid = 1'b1;
         end
      join

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
